uart_rx_os: RTL and testbench
=============================

# uart_rx_os

Parametrised, oversampling UART receiver; successor to the single-tick-per-bit receiver. It samples each bit at mid-bit using an OVERSAMPLE× baud tick, supports 5–9 data bits, optional odd/even parity and 1 or 2 stop bits, and flags parity, framing, break and overrun conditions. It sits between the pad-side `rx` line and the UART system's receive datapath, and it delivers characters over a valid/ready handshake with a one-entry holding register.

## Interface
- `DATA_BITS`, default 8: data bits per frame; legal range 5–9.
- `OVERSAMPLE`, default 16: `sample_tick` pulses per bit period; must be even and ≥4.
- `PARITY`, default 0: parity mode. 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, default 1: number of stop bits; legal values 1 or 2.
- `clk` input 1: single clock; all logic is on its rising edge.
- `reset_n` input 1: reset, asynchronous, active-low.
- `rx` input 1: serial line; asynchronous to `clk`; idles high.
- `sample_tick` input 1: one-`clk` enable pulse at OVERSAMPLE× the baud rate.
- `data_out` output DATA_BITS: received character, LSB = first bit received.
- `data_valid` output 1: holding register is full.
- `data_ready` input 1: consumer accepts the character.
- `parity_err` output 1: parity mismatch for the held character; always 0 when `PARITY`=0.
- `frame_err` output 1: one or more stop samples were 0 for the held character.
- `break_det` output 1: held frame was all-zero, covering data, parity and stop bits.
- `overrun` output 1: one or more frames were dropped while the register was full.

## Operation
- `rx` passes through a two-flop synchronizer. Both flops reset to 1. All decisions use the synchronized value `rxs`.
- All state changes happen only on cycles where `sample_tick`=1, except the handshake, which is evaluated every `clk`.
- Counters: a tick counter `ceil(log2(OVERSAMPLE))` bits wide and a bit counter `ceil(log2(DATA_BITS))` bits wide. Both restart at 0 on every state entry.
- IDLE: on a tick with `rxs`=0, clear the tick counter and go to START.
- START: on the (OVERSAMPLE/2)-th tick after entry, sample `rxs`.
  - `rxs`=1: glitch; go to IDLE with no flags.
  - `rxs`=0: go to DATA.
- DATA: sample `rxs` every OVERSAMPLE ticks and shift it in LSB-first. After DATA_BITS samples, go to PAR if `PARITY`≠0, else to STOP.
- PAR: take one sample OVERSAMPLE ticks later. Error conditions:
  - odd mode: XOR of data and parity bit is 0;
  - even mode: XOR of data and parity bit is 1.
- STOP: take STOP_BITS samples, OVERSAMPLE ticks apart.
  - `frame_err` is set if any stop sample is 0.
  - `break_det` is set if every sample in the frame (start excluded) is 0.
- Completion at the last stop sample:
  - Holding register empty, or accepted in the same cycle: load `data_out` and all three error flags, and set `data_valid`=1.
  - Otherwise: drop the frame, keep the held contents, and set `overrun`=1.
  - Next state: IDLE if the last stop sample was 1; WAIT_HIGH if it was 0.
- WAIT_HIGH: stay until a tick with `rxs`=1, then go to IDLE. This prevents a break from retriggering START.
- Handshake: the transfer happens on an edge with `data_valid` && `data_ready`.
  - On transfer, `data_valid` clears, as do `overrun` and the error flags, unless a new frame loads on the same edge. In that case `data_valid` stays 1 and the new data and flags load.
  - `data_out` and the flags are stable while `data_valid`=1.
- Elaboration rejects illegal parameters.

## Timing
- Reset (async, any state): state IDLE, counters 0, `data_out`=0, `data_valid`=0, and `parity_err`, `frame_err`, `break_det`, `overrun` all 0. Synchronizer flops go to 1.
- Reset mid-frame discards the partial frame. After `reset_n` rises, the first start bit is detected only after a fresh 1→0 on `rxs`.
- Synchronizer latency is 2 `clk` from `rx` to `rxs`.
- Let the detect tick be the first tick in IDLE with `rxs`=0. The last stop sample occurs OVERSAMPLE/2 + OVERSAMPLE·(DATA_BITS + (PARITY≠0) + STOP_BITS) ticks after the detect tick.
- `data_valid`, `data_out` and the flags are registered. They are visible on the `clk` edge that processes the last stop sample tick.
- `data_valid` falls on the edge where the transfer occurs. Back-to-back frames need no idle ticks beyond the stop bit(s).

## Test plan
- Default params, `sample_tick` every `clk`, send 0xA5 as 8N1 → `data_valid` rises 152 ticks after the detect tick, `data_out`=0xA5, all flags 0. `data_ready`=1 then clears `data_valid` next edge.
- `PARITY`=2, `DATA_BITS`=7, `STOP_BITS`=2: send 0x55 with correct parity → `parity_err`=0. Resend with the parity bit inverted → `parity_err`=1 and `data_out`=0x55.
- 8N1, drive the stop bit 0 for 0x3C → `frame_err`=1 and the FSM waits in WAIT_HIGH. Holding `rx` low for 20 bit-times (break) → exactly one character, `data_out`=0x00, `break_det`=1, and no retrigger until `rx` returns high.
- Start glitch: `rx` low for OVERSAMPLE/4 ticks, then high → no `data_valid` and the FSM returns to IDLE. A following clean 0x81 is received correctly.
- Overrun: `data_ready`=0, send 0x11 then 0x22 → `data_out` stays 0x11 and `overrun`=1. Accept → `data_valid`=0 and `overrun`=0. A frame completing on the accept edge loads with `data_valid` held at 1.
- Assert `reset_n`=0 mid-DATA of 0xF0 → all outputs 0 immediately. After release, a new 0x0F frame is received correctly with no spurious character.

Source files
------------

// File: rtl/uart_rx_os_if.sv
// Receive-side character bus of uart_rx_os: one-entry holding register with
// valid/ready handshake plus per-character status flags.
interface uart_rx_os_if #(
    parameter int DATA_BITS = 8
) ();
    // data_valid means the holding register is full. A character moves on every
    // rising clk edge where data_valid && data_ready. data_out and the flags
    // stay stable while data_valid is high. data_ready may be asserted at any time.
    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic                 data_ready;
    logic                 parity_err;
    logic                 frame_err;
    logic                 break_det;
    logic                 overrun;

    modport master (
        output data_out,
        output data_valid,
        output parity_err,
        output frame_err,
        output break_det,
        output overrun,
        input  data_ready
    );

    modport slave (
        input  data_out,
        input  data_valid,
        input  parity_err,
        input  frame_err,
        input  break_det,
        input  overrun,
        output data_ready
    );
endinterface

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: mid-bit sampling, 5-9 data bits, optional parity,
// 1/2 stop bits, parity/framing/break/overrun flags and a one-entry holding register.
module uart_rx_os #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         rx,
    input  logic         sample_tick,
    uart_rx_os_if.master bus,
    output logic [2:0]   state_dbg
);

    generate
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
            $error("uart_rx_os: DATA_BITS must be in 5..9");
        end
        if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
            $error("uart_rx_os: OVERSAMPLE must be even and >= 4");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
            $error("uart_rx_os: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
            $error("uart_rx_os: STOP_BITS must be 1 or 2");
        end
    endgenerate

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [TW-1:0] HALF_M1 = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] OS_M1   = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] DB_M1   = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] SB_M1   = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PAR       = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 seen_one_q, seen_one_d;
    logic                 stop_bad_q, stop_bad_d;
    logic                 frame_done;
    logic                 frame_perr;

    logic                 rx_meta, rxs;

    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 perr_q, ferr_q, brk_q, ovr_q;
    logic                 accept, load;

    // Two-flop synchronizer; idle-high reset value so a reset never looks like a start bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            tick_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            seen_one_q <= 1'b0;
            stop_bad_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            seen_one_q <= seen_one_d;
            stop_bad_q <= stop_bad_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        par_d      = par_q;
        seen_one_d = seen_one_q;
        stop_bad_d = stop_bad_q;
        frame_done = 1'b0;

        if (sample_tick) begin
            unique case (state_q)
                IDLE: begin
                    if (!rxs) begin
                        state_d = START;
                        tick_d  = '0;
                        bit_d   = '0;
                    end
                end
                START: begin
                    if (tick_q == HALF_M1) begin
                        tick_d = '0;
                        bit_d  = '0;
                        // A start bit that is high again at mid-bit was a glitch.
                        if (rxs) begin
                            state_d = IDLE;
                        end else begin
                            state_d    = DATA;
                            seen_one_d = 1'b0;
                            stop_bad_d = 1'b0;
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                DATA: begin
                    if (tick_q == OS_M1) begin
                        tick_d     = '0;
                        shift_d    = {rxs, shift_q[DATA_BITS-1:1]};
                        seen_one_d = seen_one_q | rxs;
                        if (bit_q == DB_M1) begin
                            bit_d   = '0;
                            state_d = (PARITY != 0) ? PAR : STOP;
                        end else begin
                            bit_d = bit_q + BW'(1);
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                PAR: begin
                    if (tick_q == OS_M1) begin
                        tick_d     = '0;
                        bit_d      = '0;
                        par_d      = rxs;
                        seen_one_d = seen_one_q | rxs;
                        state_d    = STOP;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                STOP: begin
                    if (tick_q == OS_M1) begin
                        tick_d     = '0;
                        stop_bad_d = stop_bad_q | ~rxs;
                        seen_one_d = seen_one_q | rxs;
                        if (bit_q == SB_M1) begin
                            bit_d      = '0;
                            frame_done = 1'b1;
                            // A low final stop bit may be a break; wait for the line to recover.
                            state_d    = rxs ? IDLE : WAIT_HIGH;
                        end else begin
                            bit_d = bit_q + BW'(1);
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                WAIT_HIGH: begin
                    if (rxs) begin
                        state_d = IDLE;
                        tick_d  = '0;
                        bit_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    tick_d  = '0;
                    bit_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        frame_perr = 1'b0;
        if (PARITY == 1) begin
            frame_perr = ~(^shift_q ^ par_q);
        end else if (PARITY == 2) begin
            frame_perr = ^shift_q ^ par_q;
        end
    end

    assign accept = valid_q & bus.data_ready;
    assign load   = frame_done & (~valid_q | bus.data_ready);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            brk_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else if (load) begin
            data_q  <= shift_q;
            valid_q <= 1'b1;
            perr_q  <= frame_perr;
            ferr_q  <= stop_bad_d;
            brk_q   <= ~seen_one_d;
            ovr_q   <= 1'b0;
        end else if (accept) begin
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            brk_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else if (frame_done) begin
            ovr_q <= 1'b1;
        end
    end

    assign bus.data_out   = data_q;
    assign bus.data_valid = valid_q;
    assign bus.parity_err = perr_q;
    assign bus.frame_err  = ferr_q;
    assign bus.break_det  = brk_q;
    assign bus.overrun    = ovr_q;
    assign state_dbg      = state_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: an 8N1 instance (tick every clk) and a 7E2 instance
// (tick every other clk), both checked against a frame-level reference model.
`timescale 1ns/1ps
module tb_uart_rx_os;

    localparam int OS_A = 16, DB_A = 8, PM_A = 0, SB_A = 1;
    localparam int OS_B = 8,  DB_B = 7, PM_B = 2, SB_B = 2;
    localparam int W = 12;
    localparam int ST_IDLE = 0, ST_WAIT_HIGH = 5;
    // rx edge to data_valid: 2-clk synchronizer, the detect tick, then the frame ticks.
    localparam int LAT_A = 2 + 1 + OS_A / 2 + OS_A * (DB_A + ((PM_A != 0) ? 1 : 0) + SB_A);

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic rx_a = 1'b1, rx_b = 1'b1;
    logic tick_a = 1'b1, tick_b = 1'b0;
    logic [2:0] state_a, state_b;

    int n_checks = 0, n_errors = 0;
    int chars_a = 0, chars_b = 0;
    bit abort_tx = 1'b0;

    logic [W-1:0] exp_q_a[$];
    logic [W-1:0] exp_q_b[$];

    uart_rx_os_if #(.DATA_BITS(DB_A)) bus_a ();
    uart_rx_os_if #(.DATA_BITS(DB_B)) bus_b ();

    uart_rx_os #(.DATA_BITS(DB_A), .OVERSAMPLE(OS_A), .PARITY(PM_A), .STOP_BITS(SB_A)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .rx(rx_a), .sample_tick(tick_a),
        .bus(bus_a), .state_dbg(state_a)
    );

    uart_rx_os #(.DATA_BITS(DB_B), .OVERSAMPLE(OS_B), .PARITY(PM_B), .STOP_BITS(SB_B)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .rx(rx_b), .sample_tick(tick_b),
        .bus(bus_b), .state_dbg(state_b)
    );

    // ---------------- clock / reset / tick ----------------
    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            #1 tick_b = ~tick_b;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_errors);
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic wait_ticks(input int which, input int n);
        int left;
        left = n;
        while (left > 0) begin
            @(posedge clk);
            if ((which == 0) ? tick_a : tick_b) left--;
        end
        #1;
    endtask

    task automatic set_rx(input int which, input logic v);
        if (which == 0) rx_a = v;
        else rx_b = v;
    endtask

    // Builds one frame, predicts the received character from the line bits, and drives it.
    task automatic send_frame(input int which, input logic [8:0] data, input bit flip_par,
                              input logic [1:0] stop_v, input int gap, input bit expect_char);
        int nb, os, pm, ns, ones;
        logic [8:0] d;
        logic pbit;
        bit perr, ferr, brk, aborted;
        logic bits[$];
        nb = (which == 0) ? DB_A : DB_B;
        os = (which == 0) ? OS_A : OS_B;
        pm = (which == 0) ? PM_A : PM_B;
        ns = (which == 0) ? SB_A : SB_B;
        d = data & ((9'h1 << nb) - 9'h1);
        pbit = 1'b0;
        if (pm != 0) pbit = ((pm == 2) ? ^d : ~^d) ^ flip_par;
        ones = $countones(d) + ((pm != 0 && pbit) ? 1 : 0);
        perr = (pm == 1 && (ones % 2) == 0) || (pm == 2 && (ones % 2) == 1);
        ferr = (stop_v[0] == 1'b0) || (ns == 2 && stop_v[1] == 1'b0);
        brk = (d == 9'h0) && (pbit == 1'b0) && ((ns == 1) ? !stop_v[0] : (stop_v == 2'b00));
        bits.push_back(1'b0);
        for (int i = 0; i < nb; i++) bits.push_back(d[i]);
        if (pm != 0) bits.push_back(pbit);
        for (int i = 0; i < ns; i++) bits.push_back(stop_v[i]);
        if (expect_char) begin
            if (which == 0) exp_q_a.push_back({brk, ferr, perr, d});
            else exp_q_b.push_back({brk, ferr, perr, d});
        end
        aborted = 1'b0;
        @(posedge clk);
        #1;
        foreach (bits[i]) begin
            if (abort_tx) begin
                aborted = 1'b1;
                break;
            end
            set_rx(which, bits[i]);
            wait_ticks(which, os);
        end
        if (aborted) begin
            set_rx(which, 1'b1);
        end else if (gap > 0) begin
            set_rx(which, 1'b1);
            wait_ticks(which, gap);
        end
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (reset_n && bus_a.data_valid && bus_a.data_ready) begin
            chars_a++;
            check("a_char_expected", 32'(exp_q_a.size() != 0), 32'd1);
            if (exp_q_a.size() != 0)
                check("a_char", 32'({bus_a.break_det, bus_a.frame_err, bus_a.parity_err, 9'(bus_a.data_out)}),
                      32'(exp_q_a.pop_front()));
        end
        if (reset_n && bus_b.data_valid && bus_b.data_ready) begin
            chars_b++;
            check("b_char_expected", 32'(exp_q_b.size() != 0), 32'd1);
            if (exp_q_b.size() != 0)
                check("b_char", 32'({bus_b.break_det, bus_b.frame_err, bus_b.parity_err, 9'(bus_b.data_out)}),
                      32'(exp_q_b.pop_front()));
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int c0;
        logic [8:0] d;
        logic [1:0] sv;
        bit bad;

        bus_a.data_ready = 1'b0;
        bus_b.data_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid_a", 32'(bus_a.data_valid), 32'd0);
        check("rst_data_a", 32'(bus_a.data_out), 32'd0);
        check("rst_flags_a", 32'({bus_a.parity_err, bus_a.frame_err, bus_a.break_det, bus_a.overrun}), 32'd0);
        check("rst_state_a", 32'(state_a), 32'(ST_IDLE));
        check("rst_valid_b", 32'(bus_b.data_valid), 32'd0);
        reset_n = 1'b1;
        bus_a.data_ready = 1'b1;
        bus_b.data_ready = 1'b1;
        wait_ticks(0, 2 * OS_A);

        // 0xA5 8N1: latency from the rx edge and a single-cycle valid with ready high
        fork
            send_frame(0, 9'h0A5, 1'b0, 2'b11, OS_A, 1'b1);
            begin : g_latency
                int n;
                n = 0;
                @(negedge rx_a);
                while (n < 400 && !bus_a.data_valid) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                check("a5_latency", 32'(n), 32'(LAT_A));
                @(posedge clk);
                #1;
                check("a5_valid_cleared", 32'(bus_a.data_valid), 32'd0);
            end
        join

        // 7E2: correct parity, then inverted parity bit
        send_frame(1, 9'h055, 1'b0, 2'b11, OS_B, 1'b1);
        send_frame(1, 9'h055, 1'b1, 2'b11, OS_B, 1'b1);

        // framing error, line stays low afterwards
        send_frame(0, 9'h03C, 1'b0, 2'b00, 0, 1'b1);
        wait_ticks(0, 2 * OS_A);
        check("ferr_wait_high", 32'(state_a), 32'(ST_WAIT_HIGH));
        rx_a = 1'b1;
        wait_ticks(0, OS_A);
        check("ferr_back_idle", 32'(state_a), 32'(ST_IDLE));

        // break: 20 bit-times low gives one all-zero character with framing error
        c0 = chars_a;
        exp_q_a.push_back({1'b1, 1'b1, 1'b0, 9'h000});
        @(posedge clk);
        #1;
        rx_a = 1'b0;
        wait_ticks(0, 20 * OS_A);
        check("break_during", 32'(chars_a - c0), 32'd1);
        rx_a = 1'b1;
        wait_ticks(0, 2 * OS_A);
        check("break_idle", 32'(state_a), 32'(ST_IDLE));
        check("break_one_char", 32'(chars_a - c0), 32'd1);

        // start glitch of OVERSAMPLE/4 ticks, then a clean 0x81
        c0 = chars_a;
        @(posedge clk);
        #1;
        rx_a = 1'b0;
        wait_ticks(0, OS_A / 4);
        rx_a = 1'b1;
        wait_ticks(0, 2 * OS_A);
        check("glitch_no_char", 32'(chars_a - c0), 32'd0);
        check("glitch_idle", 32'(state_a), 32'(ST_IDLE));
        send_frame(0, 9'h081, 1'b0, 2'b11, OS_A, 1'b1);

        // overrun: second frame is dropped while the register is full
        bus_a.data_ready = 1'b0;
        send_frame(0, 9'h011, 1'b0, 2'b11, OS_A, 1'b1);
        send_frame(0, 9'h022, 1'b0, 2'b11, OS_A, 1'b0);
        check("ovr_valid", 32'(bus_a.data_valid), 32'd1);
        check("ovr_data", 32'(bus_a.data_out), 32'h11);
        check("ovr_flag", 32'(bus_a.overrun), 32'd1);
        bus_a.data_ready = 1'b1;
        @(posedge clk);
        #1;
        check("ovr_accept_valid", 32'(bus_a.data_valid), 32'd0);
        check("ovr_accept_flag", 32'(bus_a.overrun), 32'd0);
        bus_a.data_ready = 1'b0;

        // a frame completing on the accept edge loads with valid held high
        send_frame(0, 9'h033, 1'b0, 2'b11, 0, 1'b1);
        fork
            send_frame(0, 9'h044, 1'b0, 2'b11, OS_A, 1'b1);
            begin : g_same_edge
                @(negedge rx_a);
                repeat (LAT_A - 1) @(posedge clk);
                #1;
                bus_a.data_ready = 1'b1;
                @(posedge clk);
                #1;
                check("same_edge_valid", 32'(bus_a.data_valid), 32'd1);
                check("same_edge_data", 32'(bus_a.data_out), 32'h44);
                check("same_edge_ovr", 32'(bus_a.overrun), 32'd0);
            end
        join

        // reset in the middle of 0xF0 with 0x5A held
        bus_a.data_ready = 1'b0;
        send_frame(0, 9'h05A, 1'b0, 2'b11, OS_A, 1'b1);
        fork
            send_frame(0, 9'h0F0, 1'b0, 2'b11, OS_A, 1'b1);
            begin : g_mid_reset
                @(negedge rx_a);
                wait_ticks(0, 4 * OS_A);
                reset_n = 1'b0;
                #1;
                check("mid_rst_valid", 32'(bus_a.data_valid), 32'd0);
                check("mid_rst_data", 32'(bus_a.data_out), 32'd0);
                check("mid_rst_flags", 32'({bus_a.parity_err, bus_a.frame_err, bus_a.break_det, bus_a.overrun}), 32'd0);
                check("mid_rst_state", 32'(state_a), 32'(ST_IDLE));
                abort_tx = 1'b1;
            end
        join
        exp_q_a.delete();
        repeat (5) @(posedge clk);
        #1;
        reset_n = 1'b1;
        abort_tx = 1'b0;
        bus_a.data_ready = 1'b1;
        wait_ticks(0, 2 * OS_A);
        c0 = chars_a;
        send_frame(0, 9'h00F, 1'b0, 2'b11, OS_A, 1'b1);
        wait_ticks(0, OS_A);
        check("post_rst_one_char", 32'(chars_a - c0), 32'd1);

        // randomized frames on both instances
        fork
            begin : g_rand_a
                for (int i = 0; i < 10; i++) begin
                    d = 9'($urandom_range(0, 255));
                    if ($urandom_range(0, 7) == 0) d = 9'h000;
                    bad = ($urandom_range(0, 4) == 0);
                    send_frame(0, d, 1'b0, {1'b1, ~bad}, bad ? OS_A + $urandom_range(0, OS_A) : $urandom_range(0, OS_A), 1'b1);
                end
            end
            begin : g_rand_b
                for (int i = 0; i < 8; i++) begin
                    d = 9'($urandom_range(0, 127));
                    if ($urandom_range(0, 5) == 0) d = 9'h000;
                    sv = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
                    send_frame(1, d, 1'($urandom_range(0, 1)), sv,
                               (sv[1] == 1'b0) ? OS_B + $urandom_range(0, OS_B) : $urandom_range(0, OS_B), 1'b1);
                end
            end
        join

        wait_ticks(0, 2 * OS_A);
        wait_ticks(1, 2 * OS_B);
        check("a_queue_drained", 32'(exp_q_a.size()), 32'd0);
        check("b_queue_drained", 32'(exp_q_b.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
